// File: rtl/regfile_pkg.sv
// Shared constants, types and reset-pattern helper for the K_DSP read-only register file.
package regfile_pkg;

    localparam int REG_COUNT   = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int INDEX_WIDTH = 5;

    typedef logic [INDEX_WIDTH-1:0] reg_index_t;
    typedef logic [DATA_WIDTH-1:0]  reg_word_t;

    // Whole storage array as one packed object so it can be handed to each read port.
    typedef logic [REG_COUNT-1:0][DATA_WIDTH-1:0] reg_array_t;

    // Reset contents of a register: its own index, zero-extended; index 0 is the zero register.
    function automatic reg_word_t init_value(input reg_index_t idx);
        reg_word_t word;
        if (idx == {INDEX_WIDTH{1'b0}}) begin
            word = {DATA_WIDTH{1'b0}};
        end else begin
            word = {{(DATA_WIDTH-INDEX_WIDTH){1'b0}}, idx};
        end
        return word;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: zero-register mux, out-of-range guard and
// output register that clears asynchronously on reset.
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  reg_array_t regs,
    input  reg_index_t index,
    output reg_word_t  rd_data
);

    // REG_COUNT expressed with one extra bit so it is representable even when it equals 2**INDEX_WIDTH.
    localparam logic [INDEX_WIDTH:0] REG_COUNT_W = REG_COUNT[INDEX_WIDTH:0];

    reg_word_t rd_word_s;
    reg_word_t rd_data_r;

    // Select the word to capture: index 0 and indices beyond the array always read zero.
    always_comb begin
        rd_word_s = {DATA_WIDTH{1'b0}};
        if (index == {INDEX_WIDTH{1'b0}}) begin
            rd_word_s = {DATA_WIDTH{1'b0}};
        end else if ({1'b0, index} < REG_COUNT_W) begin
            rd_word_s = regs[index];
        end else begin
            rd_word_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Output register; reset clears it immediately and drops any read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_data_r <= rd_word_s;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/register_file_read.sv
// Read-only register file: storage loaded with a fixed pattern on reset,
// served through two independent registered read ports (rs1, rs2).
module register_file_read
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  reg_index_t rs1_index,
    input  reg_index_t rs2_index,
    output reg_word_t  rs1_data,
    output reg_word_t  rs2_data
);

    reg_array_t regs_r;

    // Storage: reloaded with the initial pattern whenever reset is high, otherwise held constant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= init_value(reg_index_t'(i));
            end
        end else begin
            regs_r <= regs_r;
        end
    end

    regfile_read_port u_rs1_port (
        .clk     (clk),
        .reset   (reset),
        .regs    (regs_r),
        .index   (rs1_index),
        .rd_data (rs1_data)
    );

    regfile_read_port u_rs2_port (
        .clk     (clk),
        .reset   (reset),
        .regs    (regs_r),
        .index   (rs2_index),
        .rd_data (rs2_data)
    );

endmodule

// File: tb/tb_register_file_read.sv
// Self-checking bench for register_file_read: a behavioural model of the
// register file predicts both ports every cycle, plus directed literal checks.
module tb_register_file_read;
    import regfile_pkg::*;

    logic       clk;
    logic       reset;
    reg_index_t rs1_index;
    reg_index_t rs2_index;
    reg_word_t  rs1_data;
    reg_word_t  rs2_data;

    int checks;
    int failures;

    // Behavioural model: register contents and the values each port must show.
    int         model_regs [REG_COUNT];
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;

    register_file_read dut (
        .clk       (clk),
        .reset     (reset),
        .rs1_index (rs1_index),
        .rs2_index (rs2_index),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data)
    );

    // Clock, period 10, first rising edge at time 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register i holds value i after reset.
    initial begin
        for (int i = 0; i < REG_COUNT; i++) model_regs[i] = i;
    end

    function automatic logic [31:0] model_read(input int idx);
        if (idx == 0) return 32'd0;
        if (idx >= REG_COUNT) return 32'd0;
        return model_regs[idx];
    endfunction

    // Model timing: reset forces zero at once; otherwise each edge captures the indices.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_rs1 = 32'd0;
            exp_rs2 = 32'd0;
        end else begin
            exp_rs1 = model_read(int'(rs1_index));
            exp_rs2 = model_read(int'(rs2_index));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at t=%0t", name, act, req, $time);
        end
    endtask

    // Every falling edge, both ports must agree with the model.
    always @(negedge clk) begin
        chk("model_rs1", rs1_data, exp_rs1);
        chk("model_rs2", rs2_data, exp_rs2);
    end

    // Move to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        rs1_index = 5'd9;
        rs2_index = 5'd9;

        // Reset hold: outputs clear before any clock edge and stay clear.
        #1 reset = 1'b1;
        #2;
        chk("reset_hold_rs1_noedge", rs1_data, 32'h0000_0000);
        chk("reset_hold_rs2_noedge", rs2_data, 32'h0000_0000);
        #5;
        chk("reset_hold_rs1", rs1_data, 32'h0000_0000);
        chk("reset_hold_rs2", rs2_data, 32'h0000_0000);
        #3 reset = 1'b0;

        // Basic read, then stable for 10 cycles.
        rs1_index = 5'd1;
        rs2_index = 5'd4;
        step();
        chk("basic_rs1", rs1_data, 32'h0000_0001);
        chk("basic_rs2", rs2_data, 32'h0000_0004);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("stable_rs1", rs1_data, 32'h0000_0001);
            chk("stable_rs2", rs2_data, 32'h0000_0004);
        end

        // Latency: index change between edges is not visible until the next edge.
        rs1_index = 5'd7;
        #2;
        chk("latency_hold", rs1_data, 32'h0000_0001);
        step();
        chk("latency_update", rs1_data, 32'h0000_0007);

        // Zero register and top register.
        rs1_index = 5'd0;
        rs2_index = 5'd31;
        step();
        chk("zero_reg", rs1_data, 32'h0000_0000);
        chk("top_reg", rs2_data, 32'h0000_001F);

        // Sweep both ports in opposite directions.
        for (int i = 0; i < 32; i++) begin
            rs1_index = reg_index_t'(i);
            rs2_index = reg_index_t'(31 - i);
            step();
            chk("sweep_rs1", rs1_data, (i == 0) ? 32'd0 : 32'(i));
            chk("sweep_rs2", rs2_data, (i == 31) ? 32'd0 : 32'(31 - i));
        end

        // Same index on both ports.
        rs1_index = 5'd12;
        rs2_index = 5'd12;
        step();
        chk("same_rs1", rs1_data, 32'h0000_000C);
        chk("same_rs2", rs2_data, 32'h0000_000C);

        // Mid-run reset pulse between edges.
        rs1_index = 5'd5;
        rs2_index = 5'd5;
        step();
        chk("pre_reset_rs1", rs1_data, 32'h0000_0005);
        reset = 1'b1;
        #1;
        chk("mid_reset_rs1", rs1_data, 32'h0000_0000);
        chk("mid_reset_rs2", rs2_data, 32'h0000_0000);
        #1 reset = 1'b0;
        #0.5;
        chk("post_release_hold", rs1_data, 32'h0000_0000);
        step();
        chk("restore_rs1", rs1_data, 32'h0000_0005);
        chk("restore_rs2", rs2_data, 32'h0000_0005);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
